// File: rtl/sap1_ctrl_seq_if.sv
// Control bundle between the SAP-1 controller-sequencer and its datapath.
// The master drives every strobe and the ring state; the slave supplies the IR opcode.
interface sap1_ctrl_seq_if;
    logic [3:0] ir_op;
    logic       cp;
    logic       ep;
    logic       lm;
    logic       ce;
    logic       li;
    logic       ei;
    logic       la;
    logic       ea;
    logic       su;
    logic       eu;
    logic       lb;
    logic       lo;
    logic [5:0] tstate;
    logic       halted;

    modport master (
        input  ir_op,
        output cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, tstate, halted
    );

    modport slave (
        output ir_op,
        input  cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, tstate, halted
    );
endinterface

// File: rtl/sap1_ctrl_seq.sv
// SAP-1 controller-sequencer: six-state ring (T1..T6) plus a HALT state, with all
// bus strobes decoded combinationally from the ring state and the IR opcode.
module sap1_ctrl_seq (
    input  logic            clk,
    input  logic            clr,
    sap1_ctrl_seq_if.master ctl
);
    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef enum logic [2:0] {StT1, StT2, StT3, StT4, StT5, StT6, StHalt} state_e;

    state_e state_q, state_d;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= StT1;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StT1:    state_d = StT2;
            StT2:    state_d = StT3;
            StT3:    state_d = StT4;
            StT4:    state_d = (ctl.ir_op == OP_HLT) ? StHalt : StT5;
            StT5:    state_d = StT6;
            StT6:    state_d = StT1;
            StHalt:  state_d = StHalt;
            default: state_d = StT1;
        endcase
    end

    logic cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo;
    logic [5:0] tstate;
    logic       halted;

    always_comb begin
        {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo} = '0;
        tstate = 6'b000000;
        halted = 1'b0;
        unique case (state_q)
            StT1:    tstate = 6'b000001;
            StT2:    tstate = 6'b000010;
            StT3:    tstate = 6'b000100;
            StT4:    tstate = 6'b001000;
            StT5:    tstate = 6'b010000;
            StT6:    tstate = 6'b100000;
            StHalt:  halted = 1'b1;
            default: tstate = 6'b000000;
        endcase
        // Strobes are suppressed while clr is held so an abort never leaks T1 strobes.
        if (!clr) begin
            unique case (state_q)
                StT1: begin
                    ep = 1'b1;
                    lm = 1'b1;
                end
                StT2: cp = 1'b1;
                StT3: begin
                    ce = 1'b1;
                    li = 1'b1;
                end
                StT4: begin
                    case (ctl.ir_op)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            ei = 1'b1;
                            lm = 1'b1;
                        end
                        OP_OUT: begin
                            ea = 1'b1;
                            lo = 1'b1;
                        end
                        default: ;
                    endcase
                end
                StT5: begin
                    case (ctl.ir_op)
                        OP_LDA: begin
                            ce = 1'b1;
                            la = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ce = 1'b1;
                            lb = 1'b1;
                        end
                        default: ;
                    endcase
                end
                StT6: begin
                    if (ctl.ir_op == OP_ADD || ctl.ir_op == OP_SUB) begin
                        su = 1'b1;
                        la = 1'b1;
                        eu = (ctl.ir_op == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    assign ctl.cp     = cp;
    assign ctl.ep     = ep;
    assign ctl.lm     = lm;
    assign ctl.ce     = ce;
    assign ctl.li     = li;
    assign ctl.ei     = ei;
    assign ctl.la     = la;
    assign ctl.ea     = ea;
    assign ctl.su     = su;
    assign ctl.eu     = eu;
    assign ctl.lb     = lb;
    assign ctl.lo     = lo;
    assign ctl.tstate = tstate;
    assign ctl.halted = halted;
endmodule

// File: tb/tb_sap1_ctrl_seq.sv
// Bench for sap1_ctrl_seq: a small SAP-1 datapath model driven by the DUT strobes,
// with a queue of expected per-cycle strobe/state vectors checked on the falling edge.
module tb_sap1_ctrl_seq;
    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    sap1_ctrl_seq_if bus_if ();

    sap1_ctrl_seq dut (
        .clk (clk),
        .clr (clr),
        .ctl (bus_if)
    );

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Datapath model
    logic [7:0] ram [16];
    logic [3:0] pc, mar;
    logic [7:0] ir, a_reg, b_reg, out_reg, bus;
    logic       rand_mode = 1'b0;
    logic [3:0] rand_op = 4'h0;

    assign bus_if.ir_op = rand_mode ? rand_op : ir[7:4];

    always_comb begin
        bus = 8'h00;
        if (bus_if.ep) bus = {4'h0, pc};
        if (bus_if.ce) bus = ram[mar];
        if (bus_if.ei) bus = {4'h0, ir[3:0]};
        if (bus_if.ea) bus = a_reg;
        if (bus_if.su) bus = bus_if.eu ? a_reg - b_reg : a_reg + b_reg;
    end

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            pc  <= 4'h0;
            mar <= 4'h0;
            ir  <= 8'h00;
        end else begin
            if (bus_if.cp) pc <= pc + 4'h1;
            if (bus_if.lm) mar <= bus[3:0];
            if (bus_if.li) ir <= bus;
            if (bus_if.la) a_reg <= bus;
            if (bus_if.lb) b_reg <= bus;
            if (bus_if.lo) out_reg <= bus;
        end
    end

    // Expected vector: {tstate[5:0], halted, cp,ep,lm,ce,li,ei,la,ea,su,eu,lb,lo}
    logic [18:0] sbq[$];
    logic [11:0] ctrl;
    assign ctrl = {bus_if.cp, bus_if.ep, bus_if.lm, bus_if.ce, bus_if.li, bus_if.ei,
                   bus_if.la, bus_if.ea, bus_if.su, bus_if.eu, bus_if.lb, bus_if.lo};

    function automatic logic [18:0] exp_vec(input int t, input logic [3:0] op);
        logic cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo;
        logic [5:0] ts;
        logic arith;
        {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo} = '0;
        ts = 6'(1 << (t - 1));
        arith = (op == 4'h1) || (op == 4'h2);
        case (t)
            1: begin ep = 1; lm = 1; end
            2: cp = 1;
            3: begin ce = 1; li = 1; end
            4: if (op == 4'h0 || arith) begin ei = 1; lm = 1; end
               else if (op == 4'hE) begin ea = 1; lo = 1; end
            5: if (op == 4'h0) begin ce = 1; la = 1; end
               else if (arith) begin ce = 1; lb = 1; end
            6: if (arith) begin su = 1; la = 1; eu = (op == 4'h2); end
            default: ;
        endcase
        return {ts, 1'b0, cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo};
    endfunction

    task automatic push_instr(input logic [3:0] op, input int nhalt);
        if (op == 4'hF) begin
            for (int t = 1; t <= 4; t++) sbq.push_back(exp_vec(t, op));
            for (int h = 0; h < nhalt; h++) sbq.push_back({6'b000000, 1'b1, 12'h000});
        end else begin
            for (int t = 1; t <= 6; t++) sbq.push_back(exp_vec(t, op));
        end
    endtask

    always @(negedge clk) begin
        if (!clr) begin
            int drivers;
            drivers = int'(bus_if.ep) + int'(bus_if.ce) + int'(bus_if.ei) + int'(bus_if.ea)
                      + int'(bus_if.su);
            check_eq("one_driver", 32'(drivers <= 1), 32'd1);
            check_eq("ring_ok", 32'(($onehot(bus_if.tstate) && !bus_if.halted)
                     || (bus_if.tstate == 6'b0 && bus_if.halted)), 32'd1);
            check_eq("eu_only_su", 32'(!bus_if.eu || bus_if.su), 32'd1);
            if (sbq.size() > 0) begin
                logic [18:0] e;
                e = sbq.pop_front();
                check_eq("tstate", 32'(bus_if.tstate), 32'(e[18:13]));
                check_eq("halted", 32'(bus_if.halted), 32'(e[12]));
                check_eq($sformatf("ctrl_t%0h", e[18:13]), 32'(ctrl), 32'(e[11:0]));
            end
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 300 && sbq.size() != 0; i++) @(posedge clk);
        check_eq("drain_timeout", 32'(sbq.size()), 32'd0);
        sbq.delete();
        #1;
    endtask

    // Resets, queues expectations for up to two instructions, releases clr and drains.
    task automatic run_prog(input int n, input logic [3:0] o0, input logic [3:0] o1,
                            input int nhalt);
        clr = 1'b1;
        @(posedge clk);
        #1;
        push_instr(o0, nhalt);
        if (n > 1) push_instr(o1, nhalt);
        clr = 1'b0;
        wait_drain();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = 8'h00;
        a_reg = 8'h00;
        b_reg = 8'h00;
        out_reg = 8'h00;
        #1;
        check_eq("rst_tstate", 32'(bus_if.tstate), 32'h01);
        check_eq("rst_ctrl", 32'(ctrl), 32'h0);
        check_eq("rst_halted", 32'(bus_if.halted), 32'h0);

        // Abort mid-T5 of an ADD
        ram[0] = 8'h1B; ram[4'hB] = 8'h03;
        @(posedge clk); #1;
        clr = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("mid_t5_tstate", 32'(bus_if.tstate), 32'h10);
        check_eq("mid_t5_ce", 32'(bus_if.ce), 32'h1);
        clr = 1'b1;
        #1;
        check_eq("abort_ctrl", 32'(ctrl), 32'h0);
        check_eq("abort_tstate", 32'(bus_if.tstate), 32'h01);
        check_eq("abort_halted", 32'(bus_if.halted), 32'h0);

        // LDA
        ram[0] = 8'h0A; ram[4'hA] = 8'h2C;
        run_prog(1, 4'h0, 4'h0, 0);
        check_eq("lda_a", 32'(a_reg), 32'h2C);

        // ADD / SUB
        ram[0] = 8'h0A; ram[1] = 8'h1B; ram[4'hA] = 8'h05; ram[4'hB] = 8'h03;
        run_prog(2, 4'h0, 4'h1, 0);
        check_eq("add_a", 32'(a_reg), 32'h08);
        ram[1] = 8'h2B;
        run_prog(2, 4'h0, 4'h2, 0);
        check_eq("sub_a", 32'(a_reg), 32'h02);
        ram[4'hA] = 8'h03; ram[4'hB] = 8'h05;
        run_prog(2, 4'h0, 4'h2, 0);
        check_eq("sub_wrap_a", 32'(a_reg), 32'hFE);

        // OUT
        ram[1] = 8'hE0; ram[4'hA] = 8'h7F;
        run_prog(2, 4'h0, 4'hE, 0);
        check_eq("out_reg", 32'(out_reg), 32'h7F);

        // Undefined opcode leaves A and OUT untouched
        ram[0] = 8'h50;
        run_prog(1, 4'h5, 4'h0, 0);
        check_eq("nop_a", 32'(a_reg), 32'h7F);
        check_eq("nop_out", 32'(out_reg), 32'h7F);

        // HLT holds for 20 cycles, then clr restarts
        ram[0] = 8'hF0;
        run_prog(1, 4'hF, 4'h0, 20);
        check_eq("hlt_halted", 32'(bus_if.halted), 32'h1);
        ram[0] = 8'h0A; ram[4'hA] = 8'h11;
        run_prog(1, 4'h0, 4'h0, 0);
        check_eq("restart_a", 32'(a_reg), 32'h11);

        // Random program, ir_op driven directly and scrambled during fetch
        clr = 1'b1;
        rand_mode = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        for (int i = 0; i < 200; i++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 15));
            push_instr(op, 1);
            @(posedge clk); #1;
            rand_op = 4'($urandom);
            @(posedge clk); #1;
            rand_op = op;
            if (op == 4'hF) begin
                repeat (3) @(posedge clk);
                #1;
                clr = 1'b1;
                @(posedge clk); #1;
                clr = 1'b0;
            end else begin
                repeat (4) @(posedge clk);
                #1;
            end
        end
        check_eq("rand_drained", 32'(sbq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sap1_ctrl_seq.md
Name: sap1_ctrl_seq

Overview:
- Controller-sequencer for the 8-bit SAP-1 datapath; issues every control strobe on the shared tristate data bus, including the ALU's bus-drive enable (su) and add/subtract select (eu).
- Runs a six-state ring counter (T1..T6): three fetch states, then up to three execute states decoded from the instruction register opcode.
- Sole owner of bus-drive arbitration: at most one driver enable is high in any cycle.

Parameters:
- OP_LDA, 4'b0000, load A from RAM[addr]
- OP_ADD, 4'b0001, A <= A + RAM[addr]
- OP_SUB, 4'b0010, A <= A - RAM[addr]
- OP_OUT, 4'b1110, output register <= A
- OP_HLT, 4'b1111, stop sequencing until reset

Ports:
- clk  input  1  system clock; all state changes on rising edge
- clr  input  1  asynchronous, active-high reset
- ir_op  input  4  opcode (upper IR nibble); valid from T4 onward
- cp  output  1  PC increment
- ep  output  1  PC drives bus (low nibble)
- lm  output  1  MAR load from bus
- ce  output  1  RAM drives bus
- li  output  1  IR load from bus
- ei  output  1  IR drives operand nibble onto bus
- la  output  1  A register load from bus
- ea  output  1  A register drives bus
- su  output  1  ALU drives bus
- eu  output  1  ALU subtract select (0 = add, 1 = subtract)
- lb  output  1  B register load from bus
- lo  output  1  output register load from bus
- tstate  output  6  one-hot ring state, bit0 = T1 .. bit5 = T6
- halted  output  1  high while in HALT

Behaviour:
- Reset is asynchronous and active-high. While clr = 1: tstate = 6'b000001, halted = 0, and all control outputs are forced to 0.
- After clr falls, T1 strobes appear in the same cycle. A clr mid-instruction aborts immediately with no partial strobes.
- Ring advances T1->T2->...->T6->T1 on each rising edge. Exactly one tstate bit is ever high, or tstate = 0 in HALT.
- Control outputs are combinational from (tstate, ir_op, halted). No registered outputs. A register load takes effect at the rising edge ending the state in which its strobe is high.
- Fetch, independent of ir_op:
  - T1: ep, lm
  - T2: cp
  - T3: ce, li
- Execute:
  - LDA: T4 ei, lm; T5 ce, la; T6 none.
  - ADD: T4 ei, lm; T5 ce, lb; T6 su, la, eu = 0.
  - SUB: T4 ei, lm; T5 ce, lb; T6 su, la, eu = 1.
  - OUT: T4 ea, lo; T5, T6 none.
  - HLT: in T4, all strobes 0. The next rising edge enters HALT: tstate = 0, halted = 1, all outputs 0. Only clr exits.
  - Any other opcode: NOP; T4..T6 all strobes 0; ring continues to T1.
- eu is 0 in every state except SUB/T6.
- Bus invariant: ep + ce + ei + ea + su <= 1 in every cycle. A driver enable and a load of the same register are never high together.
- ir_op changing during T1..T3 has no effect on outputs.
- Fixed instruction length of 6 cycles, including NOPs. HLT takes 4 cycles to reach HALT.

Test Plan:
- Reset/fetch: assert clr mid-T5 of an ADD -> outputs 0 and tstate = 000001 without a clock edge. Release clr -> T1 {ep, lm}, T2 {cp}, T3 {ce, li} on successive cycles.
- LDA: ir_op = 0000 -> T4 {ei, lm}, T5 {ce, la}, T6 none, then back to T1. Bench datapath with RAM[0xA] = 0x2C ends with A = 0x2C.
- ADD/SUB through the ALU bench model, A = 0x05, RAM operand = 0x03:
  - ADD -> T6 su = 1, eu = 0, la = 1; A = 0x08.
  - SUB -> eu = 1; A = 0x02.
  - SUB with A = 0x03, operand 0x05 -> A = 0xFE (wrap).
- OUT: A = 0x7F, ir_op = 1110 -> T4 {ea, lo}; output register = 0x7F; T5/T6 silent.
- HLT and undefined opcode:
  - ir_op = 1111 -> after T4, halted = 1 and tstate = 0, steady for 20 cycles with all strobes 0. clr then restarts at T1.
  - ir_op = 0101 -> six cycles, no execute strobes.
- Randomized program of 200 instructions with random ir_op -> assertion checks every cycle: one-hot tstate (or HALT), at most one bus driver, eu only with su.
